mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 37 +++
 rtl/mem_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: FSM state and owner encodings, transfer
// size codes, the IO address-region tag, and the reset/zero constants.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_e;

   localparam logic [1:0]  SIZE_BYTE  = 2'd0;
   localparam logic [1:0]  SIZE_HALF  = 2'd1;
   localparam logic [1:0]  SIZE_WORD  = 2'd2;

   // addr[17:16] value that selects the IO buffer region
   localparam logic [1:0]  IO_REGION  = 2'b11;

   localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
   localparam logic        RST_ENABLE = 1'b1;

   // Number of bytes moved for a size code; code 3 behaves as a word.
   function automatic logic [2:0] xfer_len(input logic [1:0] size);
      case (size)
         SIZE_BYTE: xfer_len = 3'd1;
         SIZE_HALF: xfer_len = 3'd2;
         SIZE_WORD: xfer_len = 3'd4;
         default:   xfer_len = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetch and load/store traffic onto a
// byte-wide synchronous RAM. MEM requests win over IF requests; a granted
// transfer runs to completion and ends with a one-cycle done pulse.
// rdy=0 freezes every register and masks ram_wr and the done outputs.
// Optional build macro MEMCTRL_IOBUF_EN adds io_buffer_full, which holds off
// stores into the IO region (addr[17:16]==2'b11) while the buffer is full.
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_inst,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [1:0]  mem_size,
   input  logic [31:0] mem_wdata,
   output logic        mem_done,
   output logic [31:0] mem_rdata,
   input  logic [7:0]  ram_din,
   output logic [7:0]  ram_dout,
   output logic [31:0] ram_a,
   output logic        ram_wr,
   output logic        stallreq_if,
   output logic        stallreq_mem
`ifdef MEMCTRL_IOBUF_EN
   ,
   input  logic        io_buffer_full
`endif
);

   state_e      state, state_nxt;
   owner_e      owner;
   logic [2:0]  cnt;        // cycles spent in READ/WRITE for this transfer
   logic [2:0]  cnt_inc;
   logic [2:0]  len;        // latched byte count of the transfer
   logic [1:0]  byte_idx;   // byte landing on ram_din this cycle
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rd_buf;
   logic [31:0] rd_word;
   logic        if_done_q, mem_done_q;
   logic        grant_mem, grant_if;
   logic        io_hold;

`ifdef MEMCTRL_IOBUF_EN
   assign io_hold = mem_we && (mem_addr[17:16] == IO_REGION) && io_buffer_full;
`else
   assign io_hold = 1'b0;
`endif

   assign cnt_inc  = cnt + 3'd1;
   assign byte_idx = cnt[1:0] - 2'd1;

   assign if_done      = if_done_q  & rdy;
   assign mem_done     = mem_done_q & rdy;
   assign stallreq_if  = if_req  & ~if_done;
   assign stallreq_mem = mem_req & ~mem_done;

   // Read word with the byte currently on ram_din merged in.
   always_comb begin
      rd_word = rd_buf;
      rd_word[{byte_idx, 3'b000} +: 8] = ram_din;
   end

   // State register; rdy=0 freezes the sequence in place.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (rst == RST_ENABLE)
         state <= IDLE;
      else if (rdy)
         state <= state_nxt;
   end

   // Next-state decode, grant arbitration and the RAM write strobe.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a variable unassigned, which would infer a latch.
      state_nxt = state;
      grant_mem = 1'b0;
      grant_if  = 1'b0;
      ram_wr    = 1'b0;
      case (state)
         IDLE: begin
            if (mem_req && !io_hold) begin
               grant_mem = 1'b1;
               state_nxt = mem_we ? WRITE : READ;
            end else if (if_req) begin
               grant_if  = 1'b1;
               state_nxt = READ;
            end
         end
         READ: begin
            if (cnt == len)
               state_nxt = DONE;
         end
         WRITE: begin
            ram_wr = rdy;
            if (cnt == len - 3'd1)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: request latch, byte counter, RAM address/data, result words.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         owner      <= OWN_IF;
         cnt        <= 3'd0;
         len        <= 3'd0;
         addr_q     <= ZERO_WORD;
         wdata_q    <= ZERO_WORD;
         rd_buf     <= ZERO_WORD;
         ram_a      <= ZERO_WORD;
         ram_dout   <= 8'h00;
         if_inst    <= ZERO_WORD;
         mem_rdata  <= ZERO_WORD;
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
      end else if (rdy) begin
         if_done_q  <= (state_nxt == DONE) && (owner == OWN_IF);
         mem_done_q <= (state_nxt == DONE) && (owner == OWN_MEM);
         case (state)
            IDLE: begin
               cnt <= 3'd0;
               if (grant_mem) begin
                  owner   <= OWN_MEM;
                  len     <= xfer_len(mem_size);
                  addr_q  <= mem_addr;
                  wdata_q <= mem_wdata;
                  rd_buf  <= ZERO_WORD;
                  ram_a   <= mem_addr;
                  if (mem_we)
                     ram_dout <= mem_wdata[7:0];
               end else if (grant_if) begin
                  owner  <= OWN_IF;
                  len    <= 3'd4;
                  addr_q <= if_addr;
                  rd_buf <= ZERO_WORD;
                  ram_a  <= if_addr;
               end
            end
            READ: begin
               cnt <= cnt_inc;
               if (cnt_inc < len)
                  ram_a <= addr_q + {29'd0, cnt_inc};
               if (cnt != 3'd0)
                  rd_buf <= rd_word;
               if (cnt == len) begin
                  if (owner == OWN_IF)
                     if_inst <= rd_word;
                  else
                     mem_rdata <= rd_word;
               end
            end
            WRITE: begin
               cnt <= cnt_inc;
               if (cnt_inc < len) begin
                  ram_a    <= addr_q + {29'd0, cnt_inc};
                  ram_dout <= wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
               end
            end
            default: cnt <= 3'd0;
         endcase
      end
   end

endmodule
